// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: text segment base, halt word and the
// instruction-memory loader state encoding.
package mips_pkg;

    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } ld_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte packer: shifts bytes into a 32-bit word and flags the
// acceptance of the fourth byte of each word.
module byte_packer (
    input  logic        clock,
    input  logic        resetn,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0] count;

    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            word  <= '0;
            count <= '0;
        end else if (shift_en) begin
            word  <= {word[23:0], in_byte};
            count <= count + 2'd1;
        end
    end

    // The counter wraps to zero on its own, so each word starts clean.
    assign full = shift_en && (count == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream into words, writes them
// from the text base upward and holds the CPU until the halt word lands.
module imem_loader
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TEXT_BASE,
    parameter int          DEPTH     = 1024,
    localparam int         CW        = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    output logic          in_ready,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [CW-1:0] word_count,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic          cpu_hold
);

    ld_state_t     state;
    ld_state_t     state_next;
    logic          clear;
    logic          full;
    logic          is_halt;
    logic [31:0]   word;
    logic [31:0]   addr;
    logic [CW-1:0] count_inc;

    byte_packer u_packer (
        .clock    (clock),
        .resetn   (resetn),
        .clear    (clear),
        .shift_en (in_valid && in_ready),
        .in_byte  (in_byte),
        .word     (word),
        .full     (full)
    );

    assign is_halt   = (word == HALT_WORD);
    assign count_inc = word_count + CW'(1);

    always_ff @(posedge clock) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_COLLECT;
                    clear      = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (full) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                // A full memory leaves no slot for the terminator.
                if (is_halt)                     state_next = ST_DONE;
                else if (count_inc == CW'(DEPTH)) state_next = ST_ERROR;
                else                             state_next = ST_COLLECT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            addr       <= BASE_ADDR;
            word_count <= '0;
        end else if (state == ST_WRITE && !is_halt) begin
            addr       <= addr + 32'd4;
            word_count <= count_inc;
        end
    end

    assign in_ready  = (state == ST_COLLECT);
    assign mem_we    = (state == ST_WRITE);
    assign mem_addr  = addr;
    assign mem_wdata = word;
    assign busy      = (state == ST_COLLECT) || (state == ST_WRITE);
    assign done      = (state == ST_DONE);
    assign overflow  = (state == ST_ERROR);
    assign cpu_hold  = (state != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a default-depth and a 4-deep instance
// share one stream; the selected instance is monitored and checked.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       sel = 1'b0;

    logic        r0, we0, b0, d0, o0, h0;
    logic [31:0] a0, w0;
    logic [10:0] c0;
    logic        r1, we1, b1, d1, o1, h1;
    logic [31:0] a1, w1;
    logic [2:0]  c1;

    logic        rdy, we, busy, done, ovf, hold;
    logic [31:0] addr, wdata;
    logic [10:0] wc;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int bcnt = 0;
    int last_acc = -10;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clock(clk), .resetn(resetn), .start(start),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(r0),
        .mem_we(we0), .mem_addr(a0), .mem_wdata(w0),
        .word_count(c0), .busy(b0), .done(d0),
        .overflow(o0), .cpu_hold(h0)
    );

    imem_loader #(.DEPTH(4)) dut_small (
        .clock(clk), .resetn(resetn), .start(start),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(r1),
        .mem_we(we1), .mem_addr(a1), .mem_wdata(w1),
        .word_count(c1), .busy(b1), .done(d1),
        .overflow(o1), .cpu_hold(h1)
    );

    always_comb begin
        rdy   = sel ? r1 : r0;
        we    = sel ? we1 : we0;
        addr  = sel ? a1 : a0;
        wdata = sel ? w1 : w0;
        wc    = sel ? 11'(c1) : c0;
        busy  = sel ? b1 : b0;
        done  = sel ? d1 : d0;
        ovf   = sel ? o1 : o0;
        hold  = sel ? h1 : h0;
    end

    // Write monitor: pops the scoreboard and checks write latency.
    always @(negedge clk) begin
        logic [63:0] e;
        cyc++;
        if (!resetn) begin
            bcnt = 0;
        end else begin
            if (we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%h data=%h, required no write",
                             addr, wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({addr, wdata} !== e) begin
                        errors++;
                        $display("FAIL write: got %h@%h, required %h@%h",
                                 wdata, addr, e[31:0], e[63:32]);
                    end
                end
                checks++;
                if (cyc != last_acc + 1) begin
                    errors++;
                    $display("FAIL write_latency: got %0d cycles, required 1",
                             cyc - last_acc);
                end
            end
            if (rdy && in_valid) begin
                bcnt = (bcnt + 1) % 4;
                if (bcnt == 0) last_acc = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        resetn = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_byte = b;
        @(negedge clk);
        while (!rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout: in_ready=%b, required 1", rdy);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
        for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
    endtask

    task automatic gap3();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Called right after the terminator's last byte (cycle in WRITE).
    task automatic check_done(input string tag, input int exp_wc);
        checks++;
        if (done !== 1'b0 || hold !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_early: done=%b hold=%b, required 0 1",
                     tag, done, hold);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || hold !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b hold=%b busy=%b, required 1 0 0",
                     tag, done, hold, busy);
        end
        checks++;
        if (wc !== 11'(exp_wc)) begin
            errors++;
            $display("FAIL %s_count: got %0d, required %0d", tag, wc, exp_wc);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d writes, required 0", tag, exp_q.size());
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if ({rdy, we, busy, done, ovf, hold} !== 6'b000001) begin
            errors++;
            $display("FAIL %s_flags: rdy we busy done ovf hold=%b, required 000001",
                     tag, {rdy, we, busy, done, ovf, hold});
        end
        checks++;
        if (addr !== BASE || wdata !== 32'h0 || wc !== 11'd0) begin
            errors++;
            $display("FAIL %s_regs: addr=%h data=%h wc=%0d, required %h 0 0",
                     tag, addr, wdata, wc, BASE);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("reset");
        sel = 1'b1;
        check_reset_vals("reset_small");
        sel = 1'b0;
    endtask

    task automatic test_basic();
        sel = 1'b0;
        do_reset();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL basic_start: busy=%b rdy=%b, required 1 1", busy, rdy);
        end
        send_word(BASE, 32'h0000_0020);
        send_word(BASE + 4, 32'h0810_0000);
        send_word(BASE + 8, 32'h0000_0000);
        check_done("basic", 2);
    endtask

    task automatic test_stall();
        logic [7:0] s[12] = '{8'h00, 8'h00, 8'h00, 8'h20,
                              8'h08, 8'h10, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00};
        sel = 1'b0;
        do_reset();
        pulse_start();
        exp_q.push_back({BASE, 32'h0000_0020});
        exp_q.push_back({BASE + 32'd4, 32'h0810_0000});
        exp_q.push_back({BASE + 32'd8, 32'h0000_0000});
        for (int i = 0; i < 12; i++) begin
            send_byte(s[i]);
            if (i == 1 || i == 5) gap3();
        end
        check_done("stall", 2);
    endtask

    task automatic test_overflow();
        sel = 1'b1;
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++)
            send_word(BASE + 32'(4 * i), 32'hA5A5_0001 + 32'(i));
        @(posedge clk);
        #1;
        checks++;
        if (ovf !== 1'b1 || hold !== 1'b1 || rdy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flags: ovf=%b hold=%b rdy=%b done=%b, required 1 1 0 0",
                     ovf, hold, rdy, done);
        end
        checks++;
        if (wc !== 11'd4) begin
            errors++;
            $display("FAIL ovf_count: got %0d, required 4", wc);
        end
        pulse_start();
        checks++;
        if (ovf !== 1'b0 || busy !== 1'b1 || wc !== 11'd0 || addr !== BASE) begin
            errors++;
            $display("FAIL ovf_restart: ovf=%b busy=%b wc=%0d addr=%h, required 0 1 0 %h",
                     ovf, busy, wc, addr, BASE);
        end
        send_word(BASE, 32'h0000_0000);
        check_done("ovf_reload", 0);
        sel = 1'b0;
    endtask

    task automatic test_reset_midload();
        sel = 1'b0;
        do_reset();
        pulse_start();
        send_byte(8'hDE);
        send_byte(8'hAD);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("midload");
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (we !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midload_idle: we=%b busy=%b, required 0 0", we, busy);
        end
        pulse_start();
        send_word(BASE, 32'h1234_5678);
        send_word(BASE + 4, 32'h0000_0000);
        check_done("midload", 1);
    endtask

    task automatic test_reload();
        sel = 1'b0;
        do_reset();
        pulse_start();
        exp_q.push_back({BASE, 32'hAABB_CCDD});
        send_byte(8'hAA);
        pulse_start();
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_word(BASE + 4, 32'h0000_0000);
        check_done("reload_first", 1);
        start = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1 || hold !== 1'b0) begin
            errors++;
            $display("FAIL reload_same_cycle: done=%b hold=%b, required 1 0", done, hold);
        end
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (done !== 1'b0 || hold !== 1'b1 || wc !== 11'd0 || addr !== BASE) begin
            errors++;
            $display("FAIL reload_restart: done=%b hold=%b wc=%0d addr=%h, required 0 1 0 %h",
                     done, hold, wc, addr, BASE);
        end
        send_word(BASE, 32'h2402_000A);
        send_word(BASE + 4, 32'h0000_0000);
        check_done("reload_second", 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_reset_midload();
        test_reload();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader: the write side of the instruction memory that the fetch path (PC, +4 adder, instruction memory, control) reads. It accepts a big-endian byte stream over a valid/ready handshake, packs bytes into 32-bit words, writes them to consecutive word addresses starting at the text base, and holds the CPU until a zero terminator word has been written. A zero word is the same word that halts fetch.

## Interface

Parameters:
- BASE_ADDR, 32'h00400000, byte address of the first instruction word.
- DEPTH, 1024, instruction-memory capacity in words, terminator included.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE, DONE, ERROR
- in_valid  in  1  in_byte holds a valid byte
- in_byte  in  8  stream byte, most-significant byte of each word first
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  one-cycle write strobe to instruction memory
- mem_addr  out  32  byte address of the write; always word aligned
- mem_wdata  out  32  packed word
- word_count  out  $clog2(DEPTH+1)  non-zero words written in the current load
- busy  out  1  load in progress (COLLECT or WRITE)
- done  out  1  terminator written
- overflow  out  1  capacity exhausted with no terminator
- cpu_hold  out  1  keep the PC and CPU stalled

## Operation

States are IDLE, COLLECT, WRITE, DONE and ERROR.

- **IDLE**
  - in_ready=0.
  - start=1 → COLLECT. Clear byte count and word_count; set address to BASE_ADDR.
- **COLLECT**
  - in_ready=1.
  - On each clock edge with in_valid && in_ready: shift register ← {shift[23:0], in_byte}; byte count +1.
  - Acceptance of the 4th byte → WRITE, with the packed word registered.
- **WRITE** (exactly one cycle)
  - mem_we=1, mem_addr=current address, mem_wdata=packed word, in_ready=0.
  - Word == 0 → DONE. The terminator is written but not counted.
  - Word ≠ 0 → word_count+1, address+4. If the new word_count == DEPTH → ERROR (no slot left for the terminator); otherwise → COLLECT.
- **DONE**
  - done=1, cpu_hold=0; held until start.
  - start → COLLECT with the IDLE clearing actions; cpu_hold=1 and done=0 from the next cycle.
- **ERROR**
  - overflow=1, cpu_hold=1.
  - start → COLLECT (clear as in IDLE, overflow=0).
- **Global rules**
  - start is ignored in COLLECT and WRITE.
  - cpu_hold=1 in every state except DONE.
  - Address arithmetic is 32-bit, modulo 2^32. It cannot wrap within DEPTH from a legal BASE_ADDR.

## Timing

- **Reset values:** state=IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, busy=0, done=0, overflow=0, cpu_hold=1.
- **Reset mid-load:** state returns to IDLE on the next edge. A partial word is discarded and nothing is written for it.
- All outputs are registered or decoded from the state register. There is no combinational path from in_valid to in_ready.
- **Throughput:** at most one byte per cycle. Minimum 5 cycles per word (4 accept cycles plus 1 WRITE cycle).
- in_valid may drop at any point in COLLECT. The byte count is preserved across the gap.
- **Latency:** mem_we asserts on the cycle after the 4th byte is accepted. done and cpu_hold=0 take effect on the cycle after the terminator's WRITE.
- The memory samples mem_addr/mem_wdata on the edge ending the WRITE cycle.

## Structure

- **Shared package (mips_pkg):**
  - TEXT_BASE constant (32'h00400000), the default for BASE_ADDR.
  - Loader state enum.
  - HALT_WORD constant (32'h0). Fetch uses the same constant to stop.
- **Sub-module byte_packer:** 32-bit shift register plus a 2-bit byte counter, with clear and shift-enable inputs and word and full outputs. Instantiated once.

## Test plan

- **Basic load:** reset, start, stream 00 00 00 20 / 08 10 00 00 / 00 00 00 00 with in_valid held high.
  - Writes 0x00000020@0x00400000, 0x08100000@0x00400004, 0x00000000@0x00400008.
  - word_count=2, done=1, cpu_hold=0.
- **Stalled stream:** same stream with in_valid low for 3 cycles after bytes 2 and 6.
  - Identical writes; each mem_we occurs exactly 1 cycle after the 4th accepted byte.
- **Overflow:** DEPTH=4, stream four non-zero words.
  - After the 4th write, overflow=1, cpu_hold=1, word_count=4, in_ready=0.
  - start then restarts the load at 0x00400000.
- **Reset mid-load:** resetn low after 2 bytes of word 1.
  - No mem_we for the partial word; all outputs at reset values.
  - A fresh load writes its first word to 0x00400000.
- **Reload and ignored start:** pulse start during COLLECT → no effect. Finish the load (done=1), then start again.
  - done drops and cpu_hold rises one cycle later; word_count=0; new words go to 0x00400000.
